// File: rtl/t01_ai_move_selector.sv
// t01_ai_move_selector: scores up to 40 candidate boards one column per cycle and reports the best placement.
// Optional line-clear scoring stage is enabled by defining T01_AI_EVAL_LINES_EN.
module t01_ai_move_selector (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_eval,
    input  logic [7999:0] next_boards,
    input  logic [5:0]    valid_placements,
    input  logic [79:0]   rotations,
    input  logic [159:0]  x_positions,
    output logic          eval_busy,
    output logic          eval_done,
    output logic          no_valid,
    output logic [5:0]    best_index,
    output logic [1:0]    best_rotation,
    output logic [3:0]    best_x,
    output logic [15:0]   best_score
);
    typedef enum logic [2:0] {
        IDLE, LOAD, COLS,
`ifdef T01_AI_EVAL_LINES_EN
        LINES,
`endif
        SCORE, DONE
    } state_t;

    state_t state, nxt;
    logic [5:0] i, nc;
    logic [3:0] c;
    logic [7:0] agg, holes, bump;
    logic [4:0] prev_h, h, hc, diff, lines;
    logic [199:0] board;
    logic [15:0] s;
    logic seen;

    assign nc = valid_placements > 6'd40 ? 6'd40 : valid_placements;
    assign board = next_boards[200*i +: 200];
    assign eval_busy = state != IDLE && state != DONE;
    assign eval_done = state == DONE;

    // Height is taken from the topmost filled cell; every gap beneath it is a hole.
    always_comb begin
        seen = 1'b0;
        h = '0;
        hc = '0;
        for (int r = 0; r < 20; r++) begin
            if (board[r*10 + int'(c)] && !seen) begin
                seen = 1'b1;
                h = 5'(20 - r);
            end else if (!board[r*10 + int'(c)] && seen) begin
                hc = hc + 5'd1;
            end
        end
        diff = h >= prev_h ? h - prev_h : prev_h - h;
    end

`ifdef T01_AI_EVAL_LINES_EN
    logic [4:0] line_cnt;
    always_comb begin
        line_cnt = '0;
        for (int r = 0; r < 20; r++)
            line_cnt = line_cnt + 5'(&board[r*10 +: 10]);
    end
`else
    assign lines = '0;
`endif

    assign s = 16'({lines, 3'b000}) - 16'({agg, 1'b0}) - 16'(holes) * 16'd6 - 16'(bump);

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start_eval) nxt = valid_placements == 6'd0 ? DONE : LOAD;
            LOAD:  nxt = COLS;
`ifdef T01_AI_EVAL_LINES_EN
            COLS:  nxt = c == 4'd9 ? LINES : COLS;
            LINES: nxt = SCORE;
`else
            COLS:  nxt = c == 4'd9 ? SCORE : COLS;
`endif
            SCORE: nxt = i + 6'd1 == nc ? DONE : LOAD;
            DONE:  nxt = start_eval ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {i, c, agg, holes, bump, prev_h} <= '0;
`ifdef T01_AI_EVAL_LINES_EN
            lines <= '0;
`endif
            {no_valid, best_index, best_rotation, best_x, best_score} <= '0;
        end else begin
            case (state)
                IDLE: if (start_eval) begin
                    i <= '0;
                    no_valid <= valid_placements == 6'd0;
                    if (valid_placements == 6'd0)
                        {best_index, best_rotation, best_x, best_score} <= '0;
                end
                LOAD: begin
                    {c, agg, holes, bump, prev_h} <= '0;
`ifdef T01_AI_EVAL_LINES_EN
                    lines <= '0;
`endif
                    if (i == 6'd0) best_score <= 16'h8000;
                end
                COLS: begin
                    c <= c + 4'd1;
                    agg <= agg + 8'(h);
                    holes <= holes + 8'(hc);
                    if (c != 4'd0) bump <= bump + 8'(diff);
                    prev_h <= h;
                end
`ifdef T01_AI_EVAL_LINES_EN
                LINES: lines <= line_cnt;
`endif
                SCORE: begin
                    if ($signed(s) > $signed(best_score)) begin
                        best_index <= i;
                        best_rotation <= rotations[2*i +: 2];
                        best_x <= x_positions[4*i +: 4];
                        best_score <= s;
                    end
                    i <= i + 6'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_t01_ai_move_selector.sv
// tb_t01_ai_move_selector: directed vectors with hand-computed scores and cycle counts.
module tb_t01_ai_move_selector;
`ifdef T01_AI_EVAL_LINES_EN
    localparam int CPC = 13;
    localparam int FULL_ROW_SCORE = -12;
`else
    localparam int CPC = 12;
    localparam int FULL_ROW_SCORE = -20;
`endif

    logic clk = 0, reset = 1, start_eval = 0;
    logic [7999:0] next_boards = '0;
    logic [5:0] valid_placements = '0;
    logic [79:0] rotations = '0;
    logic [159:0] x_positions = '0;
    logic eval_busy, eval_done, no_valid;
    logic [5:0] best_index;
    logic [1:0] best_rotation;
    logic [3:0] best_x;
    logic [15:0] best_score;
    int checks = 0, failures = 0;

    t01_ai_move_selector dut (
        .clk(clk), .reset(reset), .start_eval(start_eval), .next_boards(next_boards),
        .valid_placements(valid_placements), .rotations(rotations), .x_positions(x_positions),
        .eval_busy(eval_busy), .eval_done(eval_done), .no_valid(no_valid),
        .best_index(best_index), .best_rotation(best_rotation), .best_x(best_x),
        .best_score(best_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] o_board();
        logic [199:0] b = '0;
        b[180] = 1; b[181] = 1; b[190] = 1; b[191] = 1;
        return b;
    endfunction

    function automatic logic [199:0] hole_board();
        logic [199:0] b = '0;
        for (int k = 190; k <= 198; k++) b[k] = 1;
        b[189] = 1;
        return b;
    endfunction

    function automatic logic [199:0] full_board();
        logic [199:0] b = '0;
        for (int k = 190; k <= 199; k++) b[k] = 1;
        return b;
    endfunction

    task automatic fill(input int n, input logic [199:0] b);
        next_boards = '0;
        for (int k = 0; k < 40; k++) begin
            if (k < n) next_boards[k*200 +: 200] = b;
            rotations[k*2 +: 2] = 2'((k + 1) % 4);
            x_positions[k*4 +: 4] = 4'((k * 3 + 2) % 16);
        end
    endtask

    task automatic begin_start(input bit hold);
        repeat (2) @(negedge clk);
        start_eval = 1;
        @(posedge clk);
        #1;
        if (!hold) start_eval = 0;
    endtask

    task automatic run(input string tag, input int exp);
        int n = 0, busy = 0;
        begin_start(0);
        while (!eval_done && n < 2000) begin
            if (eval_busy) busy++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_cycles"}, n, exp);
        check({tag, "_busy"}, busy, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", eval_busy, 0);
        check("rst_done", eval_done, 0);
        check("rst_score", $signed(best_score), 0);
        @(negedge clk) reset = 0;

        fill(1, o_board());
        valid_placements = 1;
        run("n1", CPC);
        check("n1_score", $signed(best_score), -10);
        check("n1_index", best_index, 0);
        check("n1_rot", best_rotation, 1);
        check("n1_x", best_x, 2);
        check("n1_novalid", no_valid, 0);

        valid_placements = 0;
        begin_start(1);
        check("n0_done", eval_done, 1);
        check("n0_busy", eval_busy, 0);
        check("n0_novalid", no_valid, 1);
        check("n0_index", best_index, 0);
        check("n0_score", $signed(best_score), 0);
        @(posedge clk);
        #1;
        check("n0_hold", eval_done, 1);
        @(negedge clk) start_eval = 0;
        @(posedge clk);
        #1;
        check("n0_release", eval_done, 0);

        fill(2, full_board());
        next_boards[199:0] = hole_board();
        valid_placements = 2;
        run("n2", 2 * CPC);
        check("n2_score", $signed(best_score), FULL_ROW_SCORE);
        check("n2_index", best_index, 1);
        check("n2_rot", best_rotation, 2);
        check("n2_x", best_x, 5);
        check("n2_novalid", no_valid, 0);

        fill(3, o_board());
        valid_placements = 3;
        run("n3", 3 * CPC);
        check("n3_index", best_index, 0);
        check("n3_score", $signed(best_score), -10);

        fill(0, '0);
        valid_placements = 63;
        run("n63", 40 * CPC);
        check("n63_score", $signed(best_score), 0);
        check("n63_index", best_index, 0);

        fill(5, o_board());
        next_boards[3*200 +: 200] = '0;
        valid_placements = 5;
        begin_start(0);
        repeat (20) @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", eval_busy, 0);
        check("mid_rst_done", eval_done, 0);
        check("mid_rst_score", $signed(best_score), 0);
        check("mid_rst_x", best_x, 0);
        @(negedge clk) reset = 0;
        run("n5", 5 * CPC);
        check("n5_index", best_index, 3);
        check("n5_score", $signed(best_score), 0);
        check("n5_x", best_x, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
